// File: rtl/dac_sample_fifo_pkg.sv
// Shared audio definitions for the DAC sample FIFO: default widths, FSM
// state encoding and the stereo frame layout used throughout the buffer.
package dac_sample_fifo_pkg;

    localparam int DAC_DATA_W     = 24;
    localparam int DAC_DEPTH_LOG2 = 4;
    localparam int DAC_PREFILL    = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_STREAM  = 2'd2
    } fifo_state_t;

    // Left channel occupies the upper half of a stored frame.
    typedef struct packed {
        logic [DAC_DATA_W-1:0] left;
        logic [DAC_DATA_W-1:0] right;
    } stereo_frame_t;

endpackage

// File: rtl/dac_fifo_ram.sv
// Simple dual-port frame store: synchronous write, combinational read,
// shaped so synthesis maps it onto distributed RAM.
module dac_fifo_ram #(
    parameter int WIDTH  = 48,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dac_sample_fifo.sv
// Stereo elastic buffer between the audio output mux and the I2S converter.
// Define DAC_FIFO_UNDERRUN_HOLD_EN to repeat the last frame on underrun.
module dac_sample_fifo
    import dac_sample_fifo_pkg::*;
#(
    parameter int DATA_W     = DAC_DATA_W,
    parameter int DEPTH_LOG2 = DAC_DEPTH_LOG2,
    parameter int PREFILL    = DAC_PREFILL
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  l_din_en,
    input  logic                  r_din_en,
    input  logic [DATA_W-1:0]     l_din,
    input  logic [DATA_W-1:0]     r_din,
    input  logic                  frame_req,
    output logic                  dout_valid,
    output logic [DATA_W-1:0]     l_dout,
    output logic [DATA_W-1:0]     r_dout,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  streaming,
    input  logic                  status_clr,
    output logic                  underrun_flag,
    output logic                  overflow_flag,
    output logic                  pair_err_flag
);

    localparam int LVL_W = DEPTH_LOG2 + 1;
    localparam int FRM_W = 2 * DATA_W;
    localparam logic [DEPTH_LOG2:0] PREFILL_LVL = LVL_W'(PREFILL);
    localparam logic [DEPTH_LOG2:0] LVL_ONE     = LVL_W'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

    fifo_state_t state, state_nxt;

    logic                  accept_en;
    logic                  left_pending;
    logic [DATA_W-1:0]     l_pend_p0;
    logic                  pend_load;
    logic                  wr_req;
    logic [FRM_W-1:0]      wr_frame;
    logic                  pair_err_set;

    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   level_nxt;
    logic                  full, empty;
    logic                  do_wr, do_pop, underrun_set, overflow_set;
    logic [FRM_W-1:0]      rd_frame;
    logic [FRM_W-1:0]      hold_frame;

    // Outside IDLE and with run high the buffer accepts traffic; anything
    // else flushes it on the next edge.
    assign accept_en = run && (state != ST_IDLE);
    assign full      = fifo_level[DEPTH_LOG2];
    assign empty     = (fifo_level == '0);

    // ---------------- pairing of left/right strobes ----------------
    always_comb begin
        wr_req       = 1'b0;
        wr_frame     = {l_din, r_din};
        pair_err_set = 1'b0;
        pend_load    = 1'b0;
        if (accept_en) begin
            if (l_din_en && r_din_en) begin
                wr_req = 1'b1;
            end else if (r_din_en) begin
                if (left_pending) begin
                    wr_req   = 1'b1;
                    wr_frame = {l_pend_p0, r_din};
                end else begin
                    pair_err_set = 1'b1;
                end
            end else if (l_din_en) begin
                pend_load    = 1'b1;
                pair_err_set = left_pending;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            left_pending <= 1'b0;
        end else if (!accept_en) begin
            left_pending <= 1'b0;
        end else if (pend_load) begin
            left_pending <= 1'b1;
        end else if (r_din_en && !l_din_en) begin
            left_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (pend_load) begin
            l_pend_p0 <= l_din;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (run) state_nxt = ST_PREFILL;
            end
            ST_PREFILL: begin
                if (!run) state_nxt = ST_IDLE;
                else if (level_nxt >= PREFILL_LVL) state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                if (!run) state_nxt = ST_IDLE;
                else if (underrun_set) state_nxt = ST_PREFILL;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs and FIFO control ----------------
    always_comb begin
        streaming    = (state == ST_STREAM);
        do_pop       = run && frame_req && streaming && !empty;
        underrun_set = run && frame_req && streaming && empty;
        // A full FIFO still takes a write when the same cycle pops a frame.
        do_wr        = wr_req && (!full || do_pop);
        overflow_set = wr_req && full && !do_pop;
        level_nxt    = fifo_level;
        if (do_wr && !do_pop) begin
            level_nxt = fifo_level + LVL_ONE;
        end else if (do_pop && !do_wr) begin
            level_nxt = fifo_level - LVL_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else if (!accept_en) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (do_wr)  wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
            fifo_level <= level_nxt;
        end
    end

    dac_fifo_ram #(
        .WIDTH  (FRM_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (do_wr),
        .waddr (wr_ptr),
        .wdata (wr_frame),
        .raddr (rd_ptr),
        .rdata (rd_frame)
    );

`ifdef DAC_FIFO_UNDERRUN_HOLD_EN
    // Output registers already carry the last popped frame after an
    // underrun, and are zero when PREFILL was entered from IDLE.
    assign hold_frame = {l_dout, r_dout};
`else
    assign hold_frame = '0;
`endif

    // ---------------- output register stage ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_valid <= 1'b0;
            l_dout     <= '0;
            r_dout     <= '0;
        end else begin
            dout_valid <= frame_req;
            if (!accept_en) begin
                l_dout <= '0;
                r_dout <= '0;
            end else if (frame_req) begin
                if (do_pop) begin
                    {l_dout, r_dout} <= rd_frame;
                end else begin
                    {l_dout, r_dout} <= hold_frame;
                end
            end
        end
    end

    // Sticky flags: a new event wins over a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun_flag <= 1'b0;
            overflow_flag <= 1'b0;
            pair_err_flag <= 1'b0;
        end else begin
            underrun_flag <= underrun_set | (underrun_flag & ~status_clr);
            overflow_flag <= overflow_set | (overflow_flag & ~status_clr);
            pair_err_flag <= pair_err_set | (pair_err_flag & ~status_clr);
        end
    end

endmodule

// File: tb/tb_dac_sample_fifo.sv
// Directed bench for dac_sample_fifo: prefill, streaming, underrun, overflow,
// pairing errors, flag clearing and run-drop flush.
module tb_dac_sample_fifo;

    localparam int DW = 24;
    localparam int DL = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          run;
    logic          l_din_en, r_din_en;
    logic [DW-1:0] l_din, r_din;
    logic          frame_req;
    logic          dout_valid;
    logic [DW-1:0] l_dout, r_dout;
    logic [DL:0]   fifo_level;
    logic          streaming;
    logic          status_clr;
    logic          underrun_flag, overflow_flag, pair_err_flag;

    int checks = 0;
    int errors = 0;

    dac_sample_fifo dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .l_din_en      (l_din_en),
        .r_din_en      (r_din_en),
        .l_din         (l_din),
        .r_din         (r_din),
        .frame_req     (frame_req),
        .dout_valid    (dout_valid),
        .l_dout        (l_dout),
        .r_dout        (r_dout),
        .fifo_level    (fifo_level),
        .streaming     (streaming),
        .status_clr    (status_clr),
        .underrun_flag (underrun_flag),
        .overflow_flag (overflow_flag),
        .pair_err_flag (pair_err_flag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
        l_din_en = 1'b1; r_din_en = 1'b1; l_din = l; r_din = r;
        tick();
        l_din_en = 1'b0; r_din_en = 1'b0;
    endtask

    task automatic request();
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
    endtask

    task automatic clear_flags();
        status_clr = 1'b1;
        tick();
        status_clr = 1'b0;
    endtask

    logic [DW-1:0] exp_l, exp_r;

    initial begin
        reset = 1'b1; run = 1'b0; l_din_en = 1'b0; r_din_en = 1'b0;
        l_din = '0; r_din = '0; frame_req = 1'b0; status_clr = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_valid", dout_valid, 0);
        chk("rst_ldout", l_dout, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_streaming", streaming, 0);
        chk("rst_flags", {underrun_flag, overflow_flag, pair_err_flag}, 0);
        reset = 1'b0;
        tick();

        // IDLE ignores writes
        write_frame(24'h0000AA, 24'h0000BB);
        chk("idle_write_ignored", fifo_level, 0);

        run = 1'b1;
        tick();
        chk("prefill_not_streaming", streaming, 0);

        // Prefill with 4 frames
        for (int i = 1; i <= 4; i++) begin
            write_frame(DW'(i), DW'(32'h100000 + i));
            if (i == 3) begin
                chk("prefill_level3", fifo_level, 3);
                chk("prefill_streaming3", streaming, 0);
            end
        end
        chk("prefill_level4", fifo_level, 4);
        chk("stream_rise", streaming, 1);

        // Pop in order, valid for one cycle, data holding
        for (int i = 1; i <= 4; i++) begin
            request();
            chk("pop_valid", dout_valid, 1);
            chk("pop_l", l_dout, 64'(i));
            chk("pop_r", r_dout, 64'(32'h100000 + i));
            tick();
            chk("pop_valid_drop", dout_valid, 0);
            chk("pop_l_hold", l_dout, 64'(i));
        end
        chk("drain_level", fifo_level, 0);
        chk("drain_streaming", streaming, 1);

        // Underrun
`ifdef DAC_FIFO_UNDERRUN_HOLD_EN
        exp_l = 24'h000004; exp_r = 24'h100004;
`else
        exp_l = 24'h0; exp_r = 24'h0;
`endif
        request();
        chk("ur_valid", dout_valid, 1);
        chk("ur_l", l_dout, exp_l);
        chk("ur_r", r_dout, exp_r);
        chk("ur_flag", underrun_flag, 1);
        chk("ur_to_prefill", streaming, 0);
        request();
        chk("prefill_req_l", l_dout, exp_l);
        chk("prefill_req_r", r_dout, exp_r);
        chk("prefill_req_level", fifo_level, 0);
        clear_flags();
        chk("ur_clear", underrun_flag, 0);

        // Overflow: 18 writes, no reads
        for (int i = 1; i <= 18; i++) begin
            write_frame(DW'(32'h200000 + i), DW'(32'h300000 + i));
        end
        chk("ovf_level", fifo_level, 16);
        chk("ovf_flag", overflow_flag, 1);
        chk("ovf_streaming", streaming, 1);
        clear_flags();
        chk("ovf_clear", overflow_flag, 0);

        // Write and pop together while full
        l_din_en = 1'b1; r_din_en = 1'b1; l_din = 24'h0000AA; r_din = 24'h0000BB;
        frame_req = 1'b1;
        tick();
        l_din_en = 1'b0; r_din_en = 1'b0; frame_req = 1'b0;
        chk("full_wp_level", fifo_level, 16);
        chk("full_wp_noovf", overflow_flag, 0);
        chk("full_wp_l", l_dout, 24'h200001);
        chk("full_wp_r", r_dout, 24'h300001);

        // New overflow with simultaneous clear keeps the flag
        status_clr = 1'b1;
        write_frame(24'h0000CC, 24'h0000DD);
        status_clr = 1'b0;
        chk("ovf_vs_clr", overflow_flag, 1);
        chk("ovf_vs_clr_level", fifo_level, 16);

        // Drain: frames 2..16 then the AA/BB frame
        for (int k = 0; k < 16; k++) begin
            if (k < 15) begin
                exp_l = DW'(32'h200002 + k); exp_r = DW'(32'h300002 + k);
            end else begin
                exp_l = 24'h0000AA; exp_r = 24'h0000BB;
            end
            request();
            chk("drain_l", l_dout, exp_l);
            chk("drain_r", r_dout, exp_r);
        end
        chk("drain2_level", fifo_level, 0);
        clear_flags();

        // Pairing: L, L, R -> error, second L stored
        l_din_en = 1'b1; l_din = 24'h000011;
        tick();
        l_din = 24'h000022;
        tick();
        l_din_en = 1'b0;
        chk("pair_ll_flag", pair_err_flag, 1);
        chk("pair_ll_level", fifo_level, 0);
        r_din_en = 1'b1; r_din = 24'h100022;
        tick();
        r_din_en = 1'b0;
        chk("pair_lr_level", fifo_level, 1);
        request();
        chk("pair_l", l_dout, 24'h000022);
        chk("pair_r", r_dout, 24'h100022);
        clear_flags();
        chk("pair_clear", pair_err_flag, 0);
        r_din_en = 1'b1; r_din = 24'h100033;
        tick();
        r_din_en = 1'b0;
        chk("pair_r_alone_level", fifo_level, 0);
        chk("pair_r_alone_flag", pair_err_flag, 1);

        // Run drop with 7 frames stored
        for (int i = 1; i <= 7; i++) begin
            write_frame(DW'(32'h400000 + i), DW'(32'h500000 + i));
        end
        chk("rundrop_level7", fifo_level, 7);
        run = 1'b0;
        tick();
        chk("rundrop_level", fifo_level, 0);
        chk("rundrop_l", l_dout, 0);
        chk("rundrop_r", r_dout, 0);
        chk("rundrop_streaming", streaming, 0);
        chk("rundrop_flag_kept", pair_err_flag, 1);
        request();
        chk("idle_req_valid", dout_valid, 1);
        chk("idle_req_l", l_dout, 0);
        chk("idle_req_r", r_dout, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
